// File: rtl/dvp_tx_pkg.sv
// Shared types and constants for the DVP transmit emulator.
package dvp_tx_pkg;

  // Frame sequencing states
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_VSYNC    = 3'd1,
    S_VBACK    = 3'd2,
    S_LINE_ACT = 3'd3,
    S_LINE_BLK = 3'd4,
    S_VFRONT   = 3'd5
  } state_e;

  // Pixel source selection codes
  localparam logic [1:0] PAT_STREAM = 2'd0;
  localparam logic [1:0] PAT_BARS   = 2'd1;
  localparam logic [1:0] PAT_RAMP   = 2'd2;
  localparam logic [1:0] PAT_SOLID  = 2'd3;

  // RGB565 colour-bar palette
  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  // Larger of two unsigned values, used for counter sizing
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Bar index 0..7 to palette colour, left to right
  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = RGB_WHITE;
      3'd1:    c = RGB_YELLOW;
      3'd2:    c = RGB_CYAN;
      3'd3:    c = RGB_GREEN;
      3'd4:    c = RGB_MAGENTA;
      3'd5:    c = RGB_RED;
      3'd6:    c = RGB_BLUE;
      default: c = RGB_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/dvp_tx_emu_if.sv
// Pixel stream input and DVP byte bus of the transmit emulator.
interface dvp_tx_emu_if;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        pix_ready;
  logic        dvp_vsync;
  logic        dvp_href;
  logic [7:0]  dvp_data;

  // Emulator side: consumes the stream, drives the DVP bus
  modport master (
    input  pix_valid,
    input  pix_data,
    output pix_ready,
    output dvp_vsync,
    output dvp_href,
    output dvp_data
  );

  // Environment side: feeds the stream, observes the DVP bus
  modport slave (
    output pix_valid,
    output pix_data,
    input  pix_ready,
    input  dvp_vsync,
    input  dvp_href,
    input  dvp_data
  );
endinterface

// File: rtl/dvp_pattern_gen.sv
// Combinational test-pattern source: pixel index and pattern code to RGB565.
module dvp_pattern_gen
  import dvp_tx_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 480,
  parameter int unsigned XW       = 9
) (
  input  logic [XW-1:0] i_x,
  input  logic [1:0]    i_pattern_sel,
  input  logic [15:0]   i_solid_rgb,
  output logic [15:0]   o_rgb_c
);

  logic [2:0] w_bar;
  logic [4:0] w_x5;
  logic [5:0] w_x6;

  assign w_bar = 3'((32'(i_x) * 32'd8) / 32'(H_ACTIVE));
  assign w_x5  = 5'(i_x);
  assign w_x6  = 6'(i_x);

  // Select generated colour; stream code yields black (top muxes stream in)
  always_comb begin
    o_rgb_c = 16'h0000;
    case (i_pattern_sel)
      PAT_BARS:  o_rgb_c = bar_colour(w_bar);
      PAT_RAMP:  o_rgb_c = {w_x5, w_x6, w_x5};
      PAT_SOLID: o_rgb_c = i_solid_rgb;
      default:   o_rgb_c = 16'h0000;
    endcase
  end

endmodule

// File: rtl/dvp_tx_emu.sv
// OV5640-style DVP source: frame/line sequencer and RGB565-to-byte serialiser.
module dvp_tx_emu
  import dvp_tx_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = 480,
  parameter int unsigned V_ACTIVE   = 272,
  parameter int unsigned H_BLANK    = 64,
  parameter int unsigned VSYNC_CYC  = 1000,
  parameter int unsigned VBACK_CYC  = 2000,
  parameter int unsigned VFRONT_CYC = 2000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         enable,
  input  logic [1:0]   pattern_sel,
  input  logic [15:0]  solid_rgb,
  dvp_tx_emu_if.master dvp,
  output logic [15:0]  frame_cnt,
  output logic         underrun
);

  localparam int unsigned CMAX = max_u(max_u(VSYNC_CYC, VBACK_CYC), max_u(H_BLANK, VFRONT_CYC));
  localparam int unsigned CW   = $clog2(CMAX + 1);
  localparam int unsigned XW   = $clog2(H_ACTIVE + 1);
  localparam int unsigned LW   = $clog2(V_ACTIVE + 1);

  localparam logic [CW-1:0] VS_LAST = CW'(VSYNC_CYC - 1);
  localparam logic [CW-1:0] VB_LAST = CW'(VBACK_CYC - 1);
  localparam logic [CW-1:0] HB_LAST = CW'(H_BLANK - 1);
  localparam logic [CW-1:0] VF_LAST = CW'(VFRONT_CYC - 1);
  localparam logic [XW-1:0] X_LAST  = XW'(H_ACTIVE - 1);
  localparam logic [LW-1:0] L_LAST  = LW'(V_ACTIVE - 1);

  state_e        r_state;
  logic [CW-1:0] r_cnt;
  logic [XW-1:0] r_x;
  logic [LW-1:0] r_line;
  logic          r_phase;
  logic [1:0]    r_pat;
  logic [15:0]   r_solid;
  logic [7:0]    r_lo;
  logic          r_vsync;
  logic          r_href;
  logic [7:0]    r_data;
  logic [15:0]   r_frame_cnt;
  logic          r_underrun;

  logic [15:0]   w_gen_rgb;
  logic [15:0]   w_pix;
  logic          w_slot;
  logic          w_stream;

  dvp_pattern_gen #(
    .H_ACTIVE (H_ACTIVE),
    .XW       (XW)
  ) u_pattern_gen (
    .i_x           (r_x),
    .i_pattern_sel (r_pat),
    .i_solid_rgb   (r_solid),
    .o_rgb_c       (w_gen_rgb)
  );

  // Phase-0 slot of an active line is where a new pixel is taken
  assign w_slot   = (r_state == S_LINE_ACT) && !r_phase;
  assign w_stream = (r_pat == PAT_STREAM);
  assign w_pix    = w_stream ? (dvp.pix_valid ? dvp.pix_data : 16'h0000) : w_gen_rgb;

  assign dvp.pix_ready = w_slot && w_stream;
  assign dvp.dvp_vsync = r_vsync;
  assign dvp.dvp_href  = r_href;
  assign dvp.dvp_data  = r_data;
  assign frame_cnt     = r_frame_cnt;
  assign underrun      = r_underrun;

  // Frame sequencer plus registered DVP outputs (one clk behind the state)
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_x         <= '0;
      r_line      <= '0;
      r_phase     <= 1'b0;
      r_pat       <= PAT_STREAM;
      r_solid     <= 16'h0000;
      r_lo        <= 8'h00;
      r_vsync     <= 1'b0;
      r_href      <= 1'b0;
      r_data      <= 8'h00;
      r_frame_cnt <= 16'h0000;
      r_underrun  <= 1'b0;
    end else begin
      r_vsync <= (r_state == S_VSYNC);
      r_href  <= (r_state == S_LINE_ACT);
      r_data  <= 8'h00;
      if (r_state == S_LINE_ACT) begin
        r_data <= r_phase ? r_lo : w_pix[15:8];
      end
      if (w_slot) begin
        r_lo <= w_pix[7:0];
      end

      // Sticky underrun, cleared together with the vsync rising edge
      if ((r_state == S_VSYNC) && !r_vsync) begin
        r_underrun <= 1'b0;
      end else if (w_slot && w_stream && !dvp.pix_valid) begin
        r_underrun <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_state <= S_VSYNC;
            r_cnt   <= '0;
            r_pat   <= pattern_sel;
            r_solid <= solid_rgb;
          end
        end
        S_VSYNC: begin
          if (r_cnt == VS_LAST) begin
            r_state <= S_VBACK;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_VBACK: begin
          if (r_cnt == VB_LAST) begin
            r_state <= S_LINE_ACT;
            r_cnt   <= '0;
            r_x     <= '0;
            r_phase <= 1'b0;
            r_line  <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_LINE_ACT: begin
          r_phase <= ~r_phase;
          if (r_phase) begin
            if (r_x == X_LAST) begin
              r_state <= S_LINE_BLK;
              r_cnt   <= '0;
            end else begin
              r_x <= r_x + 1'b1;
            end
          end
        end
        S_LINE_BLK: begin
          if (r_cnt == HB_LAST) begin
            r_cnt <= '0;
            if (r_line == L_LAST) begin
              r_state <= S_VFRONT;
            end else begin
              r_state <= S_LINE_ACT;
              r_line  <= r_line + 1'b1;
              r_x     <= '0;
              r_phase <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_VFRONT: begin
          if (r_cnt == VF_LAST) begin
            r_cnt       <= '0;
            r_frame_cnt <= r_frame_cnt + 16'd1;
            if (enable) begin
              r_state <= S_VSYNC;
              r_pat   <= pattern_sel;
              r_solid <= solid_rgb;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dvp_tx_emu.sv
// Directed frame sequence with randomized stream/background stimulus,
// checked cycle by cycle against a frame-offset reference model.
module tb_dvp_tx_emu;

  localparam int HA   = 8;
  localparam int VA   = 4;
  localparam int HB   = 4;
  localparam int VS   = 3;
  localparam int VB   = 5;
  localparam int VF   = 6;
  localparam int LP   = 2 * HA + HB;
  localparam int ACT0 = VS + VB;
  localparam int FP   = VS + VB + VA * LP + VF;
  localparam int NPIX = HA * VA;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [15:0] solid_rgb;
  logic [15:0] frame_cnt;
  logic        underrun;

  dvp_tx_emu_if u_if ();

  dvp_tx_emu #(
    .H_ACTIVE   (HA),
    .V_ACTIVE   (VA),
    .H_BLANK    (HB),
    .VSYNC_CYC  (VS),
    .VBACK_CYC  (VB),
    .VFRONT_CYC (VF)
  ) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .solid_rgb   (solid_rgb),
    .dvp         (u_if),
    .frame_cnt   (frame_cnt),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [1:0]  cur_pat;
  logic [15:0] cur_solid;
  logic        slot_valid [NPIX];
  logic [15:0] slot_val   [NPIX];
  logic [15:0] bar_tab    [8];
  logic        exp_ur;
  logic [15:0] exp_fc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Stream pixel index taken at frame offset k, or -1 outside phase-0 slots
  function automatic int slot_of(input int k);
    int r;
    if (k < ACT0 || k >= ACT0 + VA * LP) return -1;
    r = k - ACT0;
    if ((r % LP) >= 2 * HA || ((r % LP) % 2) != 0) return -1;
    return (r / LP) * HA + (r % LP) / 2;
  endfunction

  function automatic logic [15:0] ref_pixel(input int p);
    logic [15:0] xv;
    xv = 16'(p % HA);
    case (cur_pat)
      2'd0:    return slot_valid[p] ? slot_val[p] : 16'h0000;
      2'd1:    return bar_tab[((p % HA) * 8) / HA];
      2'd2:    return {xv[4:0], xv[5:0], xv[4:0]};
      default: return cur_solid;
    endcase
  endfunction

  // Expected {vsync, href, data} at output offset k of a frame
  function automatic logic [9:0] ref_bus(input int k);
    int r;
    int c;
    logic [15:0] pix;
    if (k < VS) return {1'b1, 1'b0, 8'h00};
    if (k < ACT0 || k >= ACT0 + VA * LP) return 10'h000;
    r = k - ACT0;
    c = r % LP;
    if (c >= 2 * HA) return 10'h000;
    pix = ref_pixel((r / LP) * HA + c / 2);
    return {1'b0, 1'b1, ((c % 2) == 0) ? pix[15:8] : pix[7:0]};
  endfunction

  function automatic logic [26:0] obs_bus();
    return {u_if.dvp_vsync, u_if.dvp_href, u_if.dvp_data, underrun, frame_cnt};
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      enable          = 1'b0;
      pattern_sel     = 2'($urandom);
      solid_rgb       = 16'($urandom);
      u_if.pix_valid  = 1'($urandom);
      u_if.pix_data   = 16'($urandom);
      @(posedge clk); #1;
      check("idle_bus", 32'(obs_bus()), 32'({10'h000, exp_ur, exp_fc}));
      check("idle_ready", 32'(u_if.pix_ready), 32'd0);
    end
  endtask

  // Launch a frame from IDLE; outputs still show IDLE just after the launch edge
  task automatic start_frame(input logic [1:0] pat, input logic [15:0] solid);
    cur_pat        = pat;
    cur_solid      = solid;
    enable         = 1'b1;
    pattern_sel    = pat;
    solid_rgb      = solid;
    u_if.pix_valid = 1'b0;
    @(posedge clk); #1;
    check("start_bus", 32'(obs_bus()), 32'({10'h000, exp_ur, exp_fc}));
  endtask

  task automatic fill_stream(input logic all_valid, input int force_gap);
    for (int p = 0; p < NPIX; p++) begin
      slot_valid[p] = all_valid ? 1'b1 : ($urandom_range(7) != 0);
      slot_val[p]   = all_valid ? (16'h1234 + 16'(p)) : 16'($urandom);
    end
    if (force_gap >= 0) slot_valid[force_gap] = 1'b0;
  endtask

  // One frame, offsets 0..FP-1; abort_at >= 0 pulls reset at that offset
  task automatic run_frame(input int abort_at, input logic nxt_en,
                           input logic [1:0] nxt_pat, input logic [15:0] nxt_solid);
    int vs_n;
    int hr_n;
    int rdy_n;
    int p;
    logic exp_rdy;
    logic [9:0] eb;
    vs_n = 0; hr_n = 0; rdy_n = 0;
    for (int k = 0; k < FP; k++) begin
      p = slot_of(k);
      exp_rdy = (cur_pat == 2'd0) && (p >= 0);
      check("pix_ready", 32'(u_if.pix_ready), 32'(exp_rdy));
      if (u_if.pix_ready) rdy_n++;
      if (exp_rdy) begin
        u_if.pix_valid = slot_valid[p];
        u_if.pix_data  = slot_valid[p] ? slot_val[p] : 16'($urandom);
      end else begin
        u_if.pix_valid = 1'($urandom);
        u_if.pix_data  = 16'($urandom);
      end
      if (k == FP - 1) begin
        enable = nxt_en; pattern_sel = nxt_pat; solid_rgb = nxt_solid;
      end else begin
        enable = 1'($urandom); pattern_sel = 2'($urandom); solid_rgb = 16'($urandom);
      end
      if (k == abort_at) begin
        reset_n = 1'b0;
        @(posedge clk); #1;
        exp_fc = 16'h0000;
        exp_ur = 1'b0;
        check("reset_abort", 32'({obs_bus(), u_if.pix_ready}), 32'd0);
        reset_n = 1'b1;
        return;
      end
      if (k == 0) exp_ur = 1'b0;
      if (exp_rdy && !slot_valid[p]) exp_ur = 1'b1;
      if (k == FP - 1) exp_fc = exp_fc + 16'd1;
      @(posedge clk); #1;
      eb = ref_bus(k);
      check($sformatf("bus@%0d", k), 32'(obs_bus()), 32'({eb, exp_ur, exp_fc}));
      vs_n += int'(u_if.dvp_vsync);
      hr_n += int'(u_if.dvp_href);
    end
    check("vsync_clks", 32'(vs_n), 32'(VS));
    check("href_clks", 32'(hr_n), 32'(VA * 2 * HA));
    check("ready_pulses", 32'(rdy_n), (cur_pat == 2'd0) ? 32'(NPIX) : 32'd0);
    cur_pat   = nxt_pat;
    cur_solid = nxt_solid;
  endtask

  initial begin
    bar_tab[0] = 16'hFFFF; bar_tab[1] = 16'hFFE0; bar_tab[2] = 16'h07FF; bar_tab[3] = 16'h07E0;
    bar_tab[4] = 16'hF81F; bar_tab[5] = 16'hF800; bar_tab[6] = 16'h001F; bar_tab[7] = 16'h0000;
    reset_n = 1'b0; enable = 1'b0; pattern_sel = 2'd0; solid_rgb = 16'h0000;
    u_if.pix_valid = 1'b0; u_if.pix_data = 16'h0000;
    exp_ur = 1'b0; exp_fc = 16'h0000;
    for (int p = 0; p < NPIX; p++) begin
      slot_valid[p] = 1'b1;
      slot_val[p]   = 16'h0000;
    end

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'({obs_bus(), u_if.pix_ready}), 32'd0);
    reset_n = 1'b1;
    idle_cycles(5);

    // Solid magenta, then bars, ramp, stream (all valid), stream with gaps
    start_frame(2'd3, 16'hF81F);
    run_frame(-1, 1'b1, 2'd1, 16'h0000);
    run_frame(-1, 1'b1, 2'd2, 16'($urandom));
    fill_stream(1'b1, -1);
    run_frame(-1, 1'b1, 2'd0, 16'($urandom));
    run_frame(-1, 1'b1, 2'd0, 16'($urandom));
    fill_stream(1'b0, 1 * HA + 3);
    run_frame(-1, 1'b1, 2'd3, 16'($urandom));
    // Underrun clears at this frame's vsync; enable low at its end returns to IDLE
    run_frame(-1, 1'b0, 2'd1, 16'($urandom));
    idle_cycles(8);

    // Reset mid-line aborts the frame; re-enable restarts cleanly
    start_frame(2'd2, 16'h0000);
    run_frame(ACT0 + 4, 1'b0, 2'd0, 16'h0000);
    fill_stream(1'b0, -1);
    start_frame(2'd0, 16'($urandom));
    run_frame(-1, 1'b0, 2'd0, 16'h0000);
    idle_cycles(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
